// File: rtl/x_state_buf_pkg.sv
// Shared types for the reservoir state buffer.
// Read sweep FSM encoding used by x_state_buf.
package x_state_buf_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSweep = 2'd1,
      StDrain = 2'd2
   } rd_state_e;

endpackage

// File: rtl/x_state_ram.sv
// Simple dual-port state RAM: one write port, one registered read port (1-cycle latency).
// Address is {bank, index}; contents are never reset.
module x_state_ram #(
   parameter int unsigned N  = 32,
   parameter int unsigned AW = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW:0]   waddr,
   input  logic [N-1:0]  wdata,
   input  logic          re,
   input  logic [AW:0]   raddr,
   output logic [N-1:0]  rdata
);

   localparam int unsigned Words = 2 ** (AW + 1);

   logic [N-1:0] mem_q [Words];
   logic [N-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/x_state_buf.sv
// Double-buffered reservoir state store: captures x(n) from pe and replays x(n-1)
// as an indexed read sweep; banks swap once a full state vector has been written.
module x_state_buf
   import x_state_buf_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          wr_en,
   input  logic [N-1:0]  wr_data,
   input  logic          rd_start,
   output logic          rd_valid,
   output logic [N-1:0]  rd_data,
   output logic [AW-1:0] rd_idx,
   output logic          rd_last,
   output logic          busy,
   output logic          swap_pend,
   output logic          step_done,
   output logic          ovf
);

   localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

   // Write side
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic          bank_sel_q, bank_sel_d;
   logic          init_q, init_d;
   logic          swap_pend_q, swap_pend_d;
   logic          ovf_q, ovf_d;
   logic          step_done_q, step_done_d;

   // Read side
   rd_state_e     rd_state_q, rd_state_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic          rd_bank_q, rd_bank_d;
   logic          rd_zero_q, rd_zero_d;
   logic          rd_valid_q, rd_valid_d;
   logic [AW-1:0] rd_idx_q, rd_idx_d;
   logic          rd_last_q, rd_last_d;

   logic          wr_fire;
   logic          rd_issue;
   logic          swap;
   logic [N-1:0]  ram_rdata;

   assign wr_fire  = wr_en && !swap_pend_q;
   assign rd_issue = (rd_state_q == StSweep);
   assign swap     = swap_pend_q && (rd_state_q == StIdle);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      bank_sel_d  = bank_sel_q;
      init_d      = init_q;
      swap_pend_d = swap_pend_q;
      ovf_d       = ovf_q;
      step_done_d = swap;

      if (wr_en && swap_pend_q) begin
         ovf_d = 1'b1;
      end

      if (wr_fire) begin
         if (wr_ptr_q == LastIdx) begin
            wr_ptr_d    = '0;
            swap_pend_d = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end

      // swap needs swap_pend_q, so it never coincides with an accepted write
      if (swap) begin
         bank_sel_d  = ~bank_sel_q;
         swap_pend_d = 1'b0;
         init_d      = 1'b0;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_ptr_d   = rd_ptr_q;
      rd_bank_d  = rd_bank_q;
      rd_zero_d  = rd_zero_q;

      unique case (rd_state_q)
         StIdle: begin
            if (rd_start) begin
               rd_state_d = StSweep;
               rd_ptr_d   = '0;
               // post-swap view, so a same-edge swap feeds the fresh vector
               rd_bank_d  = ~bank_sel_d;
               rd_zero_d  = init_d;
            end
         end
         StSweep: begin
            if (rd_ptr_q == LastIdx) begin
               rd_state_d = StDrain;
               rd_ptr_d   = '0;
            end else begin
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
         end
         StDrain: begin
            rd_state_d = StIdle;
         end
         default: begin
            rd_state_d = StIdle;
         end
      endcase

      rd_valid_d = rd_issue;
      rd_idx_d   = rd_issue ? rd_ptr_q : '0;
      rd_last_d  = rd_issue && (rd_ptr_q == LastIdx);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr_q    <= '0;
         bank_sel_q  <= 1'b0;
         init_q      <= 1'b1;
         swap_pend_q <= 1'b0;
         ovf_q       <= 1'b0;
         step_done_q <= 1'b0;
         rd_state_q  <= StIdle;
         rd_ptr_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_zero_q   <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_idx_q    <= '0;
         rd_last_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         bank_sel_q  <= bank_sel_d;
         init_q      <= init_d;
         swap_pend_q <= swap_pend_d;
         ovf_q       <= ovf_d;
         step_done_q <= step_done_d;
         rd_state_q  <= rd_state_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_bank_q   <= rd_bank_d;
         rd_zero_q   <= rd_zero_d;
         rd_valid_q  <= rd_valid_d;
         rd_idx_q    <= rd_idx_d;
         rd_last_q   <= rd_last_d;
      end
   end

   x_state_ram #(
      .N  (N),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_fire),
      .waddr ({bank_sel_q, wr_ptr_q}),
      .wdata (wr_data),
      .re    (rd_issue),
      .raddr ({rd_bank_q, rd_ptr_q}),
      .rdata (ram_rdata)
   );

   // RAM output register is not reset, so gate it with the valid flag
   assign rd_data   = (rd_valid_q && !rd_zero_q) ? ram_rdata : '0;
   assign rd_valid  = rd_valid_q;
   assign rd_idx    = rd_idx_q;
   assign rd_last   = rd_last_q;
   assign busy      = (rd_state_q != StIdle);
   assign swap_pend = swap_pend_q;
   assign step_done = step_done_q;
   assign ovf       = ovf_q;

endmodule
